uart_tx_fifo: RTL and testbench

// - Buffered UART transmitter: a FIFO of TX bytes with a valid/ready push side, feeding a serialiser that drives uart_txd.
// - Also generates line BREAK conditions, mirroring the break detection in uart_rx.
// - Sits between the byte producer and the uart_txd pin, so that bursts of uart_rx_valid (echo, replies) are never dropped.
//

---
 rtl/uart_tx_fifo.sv | 175 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO with valid/ready push, 8N1/8N2 serialiser
// and line BREAK generator driving uart_txd.
module uart_tx_fifo #(
  parameter int CLK_HZ     = 50000000,
  parameter int BIT_RATE   = 9600,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 1,
  parameter int BREAK_BITS = 13
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [7:0]                    s_data,
  input  logic                          send_break,
  output logic                          uart_txd,
  output logic                          uart_tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CPB = CLK_HZ / BIT_RATE;
  localparam int CW  = $clog2(CPB);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int IW  = $clog2(BREAK_BITS + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(7);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic [IW-1:0] BRK_LAST  = IW'(BREAK_BITS - 1);
  localparam logic [AW:0]   FULL      = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK, BRK_STOP} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic [7:0]    shift_reg;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [AW:0]   count_reg, count_next;
  logic          pending_reg, pending_next;
  logic          txd_reg, txd_next;
  logic          busy_reg, busy_next;
  logic          push, pop, shift_en, last_tick;

  assign s_ready      = (count_reg != FULL);
  assign push         = s_valid && s_ready;
  assign last_tick    = (cnt_reg == CNT_LAST);
  assign uart_txd     = txd_reg;
  assign uart_tx_busy = busy_reg;
  assign fifo_count   = count_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = (state_reg == IDLE) ? '0 : (last_tick ? '0 : cnt_reg + CW'(1));
    idx_next   = idx_reg;
    pop        = 1'b0;
    shift_en   = 1'b0;
    txd_next   = 1'b1;
    case (state_reg)
      IDLE: begin
        // A pending break wins over queued data.
        if (pending_reg) begin
          state_next = BREAK;
          idx_next   = '0;
        end else if (count_reg != '0) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        txd_next = 1'b0;
        if (last_tick) begin
          state_next = DATA;
          idx_next   = '0;
        end
      end
      DATA: begin
        txd_next = shift_reg[0];
        if (last_tick) begin
          shift_en = 1'b1;
          if (idx_reg == DATA_LAST) begin
            state_next = STOP;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + IW'(1);
          end
        end
      end
      STOP: begin
        if (last_tick) begin
          if (idx_reg == STOP_LAST) begin
            state_next = IDLE;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + IW'(1);
          end
        end
      end
      BREAK: begin
        txd_next = 1'b0;
        if (last_tick) begin
          if (idx_reg == BRK_LAST) begin
            state_next = BRK_STOP;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + IW'(1);
          end
        end
      end
      BRK_STOP: begin
        if (last_tick) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pending_next = pending_reg;
    if (state_reg == IDLE && pending_reg) begin
      pending_next = 1'b0;
    end else if (send_break && state_reg != BREAK) begin
      pending_next = 1'b1;
    end
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + (AW + 1)'(1);
      2'b01:   count_next = count_reg - (AW + 1)'(1);
      default: count_next = count_reg;
    endcase
    busy_next = (state_next != IDLE) || (count_next != '0) || pending_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      idx_reg     <= '0;
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
      count_reg   <= '0;
      pending_reg <= 1'b0;
      txd_reg     <= 1'b1;
      busy_reg    <= 1'b0;
      shift_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      idx_reg     <= idx_next;
      count_reg   <= count_next;
      pending_reg <= pending_next;
      txd_reg     <= txd_next;
      busy_reg    <= busy_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
        shift_reg  <= mem[rd_ptr_reg];
      end else if (shift_en) begin
        shift_reg  <= {1'b0, shift_reg[7:1]};
      end
    end
  end

  // Storage kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= s_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 10 clk/bit, depth 4; second instance uses 2 stop bits.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_valid, s_ready, send_break, txd, busy;
  logic [7:0] s_data;
  logic [2:0] count;
  logic       s_valid_2, s_ready_2, send_break_2, txd_2, busy_2;
  logic [7:0] s_data_2;
  logic [2:0] count_2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_HZ(100), .BIT_RATE(10), .FIFO_DEPTH(4), .STOP_BITS(1), .BREAK_BITS(13)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .send_break(send_break), .uart_txd(txd), .uart_tx_busy(busy), .fifo_count(count)
  );

  uart_tx_fifo #(.CLK_HZ(100), .BIT_RATE(10), .FIFO_DEPTH(4), .STOP_BITS(2), .BREAK_BITS(13)) dut2 (
    .clk(clk), .reset(reset), .s_valid(s_valid_2), .s_ready(s_ready_2), .s_data(s_data_2),
    .send_break(send_break_2), .uart_txd(txd_2), .uart_tx_busy(busy_2), .fifo_count(count_2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_txd(input bit which, input logic v, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      chk(tag, which ? txd_2 : txd, v);
      tick();
    end
  endtask

  task automatic check_frame(input bit which, input logic [7:0] b, input int start_len,
                             input int stop_len, input string tag);
    expect_txd(which, 1'b0, start_len, {tag, " start"});
    for (int k = 0; k < 8; k++) begin
      expect_txd(which, b[k], 10, $sformatf("%s d%0d", tag, k));
    end
    expect_txd(which, 1'b1, stop_len, {tag, " stop"});
    $display("[%0t] dut%0d frame 0x%02h checked", $time, which ? 2 : 1, b);
  endtask

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_data = '0; send_break = 1'b0;
    s_valid_2 = 1'b0; s_data_2 = '0; send_break_2 = 1'b0;
    tick(); tick();
    chk("rst txd", txd, 1'b1);
    chk("rst s_ready", s_ready, 1'b1);
    chk("rst busy", busy, 1'b0);
    chk("rst count", count, 3'd0);
    reset = 1'b0;
    tick();

    // Single byte 0xA5: latency N+2 and busy falling edge.
    s_valid = 1'b1; s_data = 8'hA5;
    tick();
    s_valid = 1'b0;
    chk("a5 busy up", busy, 1'b1);
    chk("a5 count", count, 3'd1);
    chk("a5 txd N", txd, 1'b1);
    tick();
    chk("a5 txd N+1", txd, 1'b1);
    tick();
    check_frame(0, 8'hA5, 10, 8, "a5");
    chk("a5 busy last stop", busy, 1'b1);
    tick();
    chk("a5 busy down", busy, 1'b0);
    chk("a5 txd idle", txd, 1'b1);
    chk("a5 count end", count, 3'd0);

    // Burst of five bytes plus a sixth held while full.
    s_valid = 1'b1;
    s_data = 8'h00; tick();
    s_data = 8'hFF; tick();
    s_data = 8'h55; tick();
    s_data = 8'h0F; tick();
    s_data = 8'hF0; tick();
    chk("burst count full", count, 3'd4);
    chk("burst s_ready full", s_ready, 1'b0);
    s_data = 8'hC3;
    check_frame(0, 8'h00, 8, 10, "b00");
    chk("burst count pop", count, 3'd3);
    chk("burst s_ready pop", s_ready, 1'b1);
    expect_txd(0, 1'b1, 1, "burst gap");
    chk("burst count refill", count, 3'd4);
    chk("burst s_ready refill", s_ready, 1'b0);
    s_valid = 1'b0;
    check_frame(0, 8'hFF, 10, 11, "bFF");
    check_frame(0, 8'h55, 10, 11, "b55");
    check_frame(0, 8'h0F, 10, 11, "b0F");
    check_frame(0, 8'hF0, 10, 11, "bF0");
    check_frame(0, 8'hC3, 10, 10, "bC3");
    chk("burst busy end", busy, 1'b0);
    chk("burst count end", count, 3'd0);

    // BREAK with 0x3C queued; second pulse mid-break must be absorbed.
    send_break = 1'b1; s_valid = 1'b1; s_data = 8'h3C;
    tick();
    send_break = 1'b0; s_valid = 1'b0;
    chk("brk busy", busy, 1'b1);
    chk("brk count", count, 3'd1);
    tick();
    chk("brk txd B+1", txd, 1'b1);
    chk("brk priority count", count, 3'd1);
    tick();
    expect_txd(0, 1'b0, 48, "brk low a");
    send_break = 1'b1;
    expect_txd(0, 1'b0, 1, "brk low b");
    send_break = 1'b0;
    expect_txd(0, 1'b0, 81, "brk low c");
    expect_txd(0, 1'b1, 11, "brk stop");
    $display("[%0t] dut1 break checked", $time);
    check_frame(0, 8'h3C, 10, 10, "b3C");
    chk("brk busy end", busy, 1'b0);
    expect_txd(0, 1'b1, 20, "brk no repeat");
    chk("brk busy quiet", busy, 1'b0);

    // Reset 35 clocks into a 0x81 frame with 0x7E still queued.
    s_valid = 1'b1; s_data = 8'h81;
    tick();
    s_data = 8'h7E;
    tick();
    s_valid = 1'b0;
    chk("rst81 count", count, 3'd1);
    tick();
    expect_txd(0, 1'b0, 10, "rst81 start");
    expect_txd(0, 1'b1, 10, "rst81 d0");
    expect_txd(0, 1'b0, 15, "rst81 d1d2");
    reset = 1'b1;
    tick();
    chk("midrst txd", txd, 1'b1);
    chk("midrst count", count, 3'd0);
    chk("midrst busy", busy, 1'b0);
    chk("midrst s_ready", s_ready, 1'b1);
    reset = 1'b0;
    expect_txd(0, 1'b1, 25, "midrst no resume");
    chk("midrst busy idle", busy, 1'b0);
    $display("[%0t] dut1 mid-frame reset checked", $time);
    s_valid = 1'b1; s_data = 8'h81;
    tick();
    s_valid = 1'b0;
    chk("fresh count", count, 3'd1);
    tick();
    chk("fresh txd N+1", txd, 1'b1);
    tick();
    check_frame(0, 8'h81, 10, 10, "f81");
    chk("fresh busy end", busy, 1'b0);
    chk("fresh count end", count, 3'd0);

    // Two stop bits: 0x01 twice.
    s_valid_2 = 1'b1; s_data_2 = 8'h01;
    tick();
    tick();
    s_valid_2 = 1'b0;
    chk("sb2 count", count_2, 3'd1);
    chk("sb2 txd N+1", txd_2, 1'b1);
    tick();
    check_frame(1, 8'h01, 10, 21, "sb2 f1");
    check_frame(1, 8'h01, 10, 20, "sb2 f2");
    chk("sb2 busy end", busy_2, 1'b0);
    chk("sb2 count end", count_2, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
